// File: rtl/cavlc_bit_window.sv
// rtl/cavlc_bit_window.sv - 64-bit left-aligned bit window feeding the CAVLC barrel shifter
// Optional build macro CAVLC_BITWIN_BYTESWAP_EN: byte-reverse InData for little-endian word sources.
module cavlc_bit_window (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    input  logic        ShiftEn,
    input  logic [4:0]  NumShift,
    input  logic        Flush,
    output logic [31:0] BitWindow,
    output logic        BarrelShifterReady,
    output logic [6:0]  BitCount,
    output logic        Underflow
);

    logic [63:0] bufReg;
    logic [63:0] bufNext;
    logic [6:0]  countReg;
    logic [6:0]  countNext;
    logic        underflowReg;
    logic        underflowNext;

    logic [31:0] inWord;
    logic [6:0]  shiftReq;
    logic [6:0]  shiftAmt;
    logic [6:0]  countAfterShift;
    logic        shiftLegal;
    logic        shiftIllegal;
    logic        loadWord;
    logic [63:0] shiftedBuf;
    logic [63:0] insertBits;

`ifdef CAVLC_BITWIN_BYTESWAP_EN
    assign inWord = {InData[7:0], InData[15:8], InData[23:16], InData[31:24]};
`else
    assign inWord = InData;
`endif

    assign shiftReq     = {2'b00, NumShift};
    assign shiftLegal   = ShiftEn && (NumShift != 5'd0) && (shiftReq <= countReg);
    assign shiftIllegal = ShiftEn && (shiftReq > countReg);
    assign shiftAmt     = shiftLegal ? shiftReq : 7'd0;

    // InReady comes from registered Count, so a load never overruns the 64-bit buffer.
    assign loadWord = InValid && InReady && !Flush;

    assign countAfterShift = countReg - shiftAmt;
    assign shiftedBuf      = bufReg << shiftAmt;
    // New word lands directly below the surviving bits of the shifted buffer.
    assign insertBits      = {inWord, 32'h0000_0000} >> countAfterShift;

    always_comb begin
        bufNext       = bufReg;
        countNext     = countReg;
        underflowNext = underflowReg;
        if (Flush) begin
            bufNext       = 64'h0;
            countNext     = 7'd0;
            underflowNext = 1'b0;
        end else begin
            bufNext       = shiftedBuf | (loadWord ? insertBits : 64'h0);
            countNext     = countAfterShift + (loadWord ? 7'd32 : 7'd0);
            underflowNext = underflowReg | shiftIllegal;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bufReg       <= 64'h0;
            countReg     <= 7'd0;
            underflowReg <= 1'b0;
        end else begin
            bufReg       <= bufNext;
            countReg     <= countNext;
            underflowReg <= underflowNext;
        end
    end

    assign InReady            = (countReg <= 7'd32);
    assign BarrelShifterReady = (countReg >= 7'd32);
    assign BitCount           = countReg;
    assign BitWindow          = bufReg[63:32];
    assign Underflow          = underflowReg;

endmodule

// File: tb/tb_cavlc_bit_window.sv
// tb/tb_cavlc_bit_window.sv - self-checking bench for cavlc_bit_window against a bit-queue model
module tb_cavlc_bit_window;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] InData;
    logic        InValid;
    logic        InReady;
    logic        ShiftEn;
    logic [4:0]  NumShift;
    logic        Flush;
    logic [31:0] BitWindow;
    logic        BarrelShifterReady;
    logic [6:0]  BitCount;
    logic        Underflow;

    int checks = 0;
    int failures = 0;

    bit   mq[$];
    logic mUf;

    cavlc_bit_window dut (
        .Clk(Clk),
        .nReset(nReset),
        .InData(InData),
        .InValid(InValid),
        .InReady(InReady),
        .ShiftEn(ShiftEn),
        .NumShift(NumShift),
        .Flush(Flush),
        .BitWindow(BitWindow),
        .BarrelShifterReady(BarrelShifterReady),
        .BitCount(BitCount),
        .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] stream_word(input logic [31:0] d);
`ifdef CAVLC_BITWIN_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] m_window();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 32; i++)
            if (i < mq.size()) w[31-i] = mq[i];
        return w;
    endfunction

    // Drive one cycle of inputs, advance one edge, and update the bit-queue model.
    task automatic step(input logic iv, input logic [31:0] d, input logic se,
                        input logic [4:0] ns, input logic fl, output logic acc);
        int pre;
        bit tmp;
        logic [31:0] w;
        InValid  = iv;
        InData   = d;
        ShiftEn  = se;
        NumShift = ns;
        Flush    = fl;
        pre = mq.size();
        acc = 1'b0;
        @(posedge Clk);
        if (fl) begin
            mq.delete();
            mUf = 1'b0;
        end else begin
            if (se && ns != 5'd0) begin
                if (int'(ns) <= pre) begin
                    for (int k = 0; k < int'(ns); k++) tmp = mq.pop_front();
                end else begin
                    mUf = 1'b1;
                end
            end
            if (iv && pre <= 32) begin
                w = stream_word(d);
                for (int k = 31; k >= 0; k--) mq.push_back(w[k]);
                acc = 1'b1;
            end
        end
        #1;
        InValid = 1'b0;
        ShiftEn = 1'b0;
        Flush   = 1'b0;
    endtask

    task automatic test_reset();
        logic acc;
        nReset = 1'b0; InValid = 1'b0; InData = 32'h0; ShiftEn = 1'b0; NumShift = 5'd0; Flush = 1'b0;
        mq.delete(); mUf = 1'b0;
        #2;
        checks++; if (BitCount !== 7'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", BitCount); end
        checks++; if (BitWindow !== 32'h0) begin failures++; $display("FAIL reset_window actual=%h expected=00000000", BitWindow); end
        checks++; if ({InReady, BarrelShifterReady, Underflow} !== 3'b100) begin failures++; $display("FAIL reset_flags actual=%b expected=100", {InReady, BarrelShifterReady, Underflow}); end
        InValid = 1'b1; InData = 32'hAAAA5555;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (BitCount !== 7'd0) begin failures++; $display("FAIL reset_ignores_word actual=%0d expected=0", BitCount); end
        nReset = 1'b1; InValid = 1'b0;
        step(1'b1, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, acc);
        checks++; if (BitCount !== 7'd32) begin failures++; $display("FAIL first_edge_load actual=%0d expected=32", BitCount); end
        #2; nReset = 1'b0; #1;
        checks++; if ({BitCount, BitWindow} !== 39'h0) begin failures++; $display("FAIL async_reset_midstream actual=%0d/%h expected=0/00000000", BitCount, BitWindow); end
        @(posedge Clk); #1;
        nReset = 1'b1;
        mq.delete(); mUf = 1'b0;
    endtask

    task automatic test_load_shift();
        logic acc;
        step(1'b1, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, acc);
        checks++; if (BitWindow !== stream_word(32'hDEADBEEF)) begin failures++; $display("FAIL load_window actual=%h expected=%h", BitWindow, stream_word(32'hDEADBEEF)); end
        checks++; if (BitCount !== 7'd32) begin failures++; $display("FAIL load_count actual=%0d expected=32", BitCount); end
        checks++; if ({BarrelShifterReady, InReady} !== 2'b11) begin failures++; $display("FAIL load_flags actual=%b expected=11", {BarrelShifterReady, InReady}); end
        step(1'b1, 32'h12345678, 1'b1, 5'd8, 1'b0, acc);
`ifndef CAVLC_BITWIN_BYTESWAP_EN
        checks++; if (BitWindow !== 32'hADBEEF12) begin failures++; $display("FAIL shift_load_window actual=%h expected=adbeef12", BitWindow); end
`endif
        checks++; if (BitWindow !== m_window()) begin failures++; $display("FAIL shift_load_model actual=%h expected=%h", BitWindow, m_window()); end
        checks++; if (BitCount !== 7'd56) begin failures++; $display("FAIL shift_load_count actual=%0d expected=56", BitCount); end
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL shift_load_inready actual=%b expected=0", InReady); end
    endtask

    task automatic test_backpressure();
        logic acc;
        step(1'b1, 32'hCAFEF00D, 1'b1, 5'd16, 1'b0, acc);
        checks++; if (BitCount !== 7'd40) begin failures++; $display("FAIL bp_hold1_count actual=%0d expected=40", BitCount); end
        step(1'b1, 32'hCAFEF00D, 1'b1, 5'd8, 1'b0, acc);
        checks++; if (BitCount !== 7'd32) begin failures++; $display("FAIL bp_hold2_count actual=%0d expected=32", BitCount); end
        step(1'b1, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, acc);
        checks++; if (BitCount !== 7'd64) begin failures++; $display("FAIL bp_accept_count actual=%0d expected=64", BitCount); end
        checks++; if (BitWindow !== stream_word(32'h12345678)) begin failures++; $display("FAIL bp_accept_window actual=%h expected=%h", BitWindow, stream_word(32'h12345678)); end
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL bp_full_inready actual=%b expected=0", InReady); end
    endtask

    task automatic test_underflow();
        logic acc;
        step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, acc);
        step(1'b1, 32'h0F0F0F0F, 1'b0, 5'd0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, 5'd28, 1'b0, acc);
        checks++; if (BitCount !== 7'd4) begin failures++; $display("FAIL uf_pre_count actual=%0d expected=4", BitCount); end
        step(1'b0, 32'h0, 1'b1, 5'd5, 1'b0, acc);
        checks++; if (Underflow !== 1'b1) begin failures++; $display("FAIL uf_set actual=%b expected=1", Underflow); end
        checks++; if (BitCount !== 7'd4) begin failures++; $display("FAIL uf_count_kept actual=%0d expected=4", BitCount); end
        checks++; if (BitWindow !== m_window()) begin failures++; $display("FAIL uf_window_kept actual=%h expected=%h", BitWindow, m_window()); end
        step(1'b0, 32'h0, 1'b1, 5'd3, 1'b0, acc);
        checks++; if ({Underflow, BitCount} !== {1'b1, 7'd1}) begin failures++; $display("FAIL uf_sticky actual=%b/%0d expected=1/1", Underflow, BitCount); end
        step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, acc);
        checks++; if ({Underflow, BitCount} !== 8'h00) begin failures++; $display("FAIL uf_flush_clear actual=%b/%0d expected=0/0", Underflow, BitCount); end
    endtask

    task automatic test_flush_priority();
        logic acc;
        step(1'b1, 32'h55AA55AA, 1'b0, 5'd0, 1'b0, acc);
        step(1'b1, 32'h13579BDF, 1'b1, 5'd4, 1'b1, acc);
        checks++; if (BitCount !== 7'd0) begin failures++; $display("FAIL flush_count actual=%0d expected=0", BitCount); end
        checks++; if (BitWindow !== 32'h0) begin failures++; $display("FAIL flush_window actual=%h expected=00000000", BitWindow); end
        checks++; if ({InReady, BarrelShifterReady} !== 2'b10) begin failures++; $display("FAIL flush_flags actual=%b expected=10", {InReady, BarrelShifterReady}); end
    endtask

    task automatic test_byteswap();
        logic acc;
        logic [31:0] exp;
`ifdef CAVLC_BITWIN_BYTESWAP_EN
        exp = 32'h44332211;
`else
        exp = 32'h11223344;
`endif
        step(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, acc);
        step(1'b1, 32'h11223344, 1'b0, 5'd0, 1'b0, acc);
        checks++; if (BitWindow !== exp) begin failures++; $display("FAIL byte_order actual=%h expected=%h", BitWindow, exp); end
    endtask

    task automatic test_random();
        logic        acc;
        logic [31:0] pendWord;
        logic        pendValid;
        logic        se;
        logic        fl;
        logic [4:0]  ns;
        pendWord  = $urandom;
        pendValid = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            se = ($urandom_range(0, 3) != 0);
            ns = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0 && mq.size() < 31) ns = 5'(mq.size() + 1);
            fl = ($urandom_range(0, 59) == 0);
            checks++; if (InReady !== (mq.size() <= 32)) begin failures++; $display("FAIL rnd_inready cycle=%0d actual=%b expected=%b", n, InReady, mq.size() <= 32); end
            step(pendValid, pendWord, se, ns, fl, acc);
            if (acc) begin
                pendWord  = $urandom;
                pendValid = ($urandom_range(0, 4) != 0);
            end else if (!pendValid) begin
                pendValid = ($urandom_range(0, 1) != 0);
            end
            checks++; if (BitWindow !== m_window()) begin failures++; $display("FAIL rnd_window cycle=%0d actual=%h expected=%h", n, BitWindow, m_window()); end
            checks++; if (int'(BitCount) != mq.size()) begin failures++; $display("FAIL rnd_count cycle=%0d actual=%0d expected=%0d", n, BitCount, mq.size()); end
            checks++; if (BarrelShifterReady !== (mq.size() >= 32)) begin failures++; $display("FAIL rnd_bsready cycle=%0d actual=%b expected=%b", n, BarrelShifterReady, mq.size() >= 32); end
            checks++; if (Underflow !== mUf) begin failures++; $display("FAIL rnd_underflow cycle=%0d actual=%b expected=%b", n, Underflow, mUf); end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_backpressure();
        test_underflow();
        test_flush_priority();
        test_byteswap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
